titan_fetch_ctrl: RTL
=====================

# titan_fetch_ctrl

Instruction-fetch bus controller for the Titan IF stage. It drives the Wishbone-classic instruction port from the current PC and stalls the PC register/IF-ID path until a response arrives. It holds a returned instruction while decode is stalled and discards in-flight responses made stale by a branch, jump or flush. Bus errors are forwarded as an access fault with a NOP payload.

## Interface
- RESET_ADDR, 32'h0000_0000, reset PC; used only for the reset value of the latched address.
- NOP_INST, 32'h0000_0013, instruction word returned on fault, reset or kill.

- clk_i  in  1  single clock.
- rst_i  in  1  reset. Synchronous, active-high.
- if_pc_i  in  32  current PC from the PC register.
- if_redirect_i  in  1  non-sequential PC load this cycle (pc_sel != 0 or IF flush).
- id_stall_i  in  1  IF/ID register cannot accept.
- if_stall_o  out  1  fetch-side stall, to PC register and IF/ID.
- if_kill_o  out  1  IF/ID captures a bubble this cycle.
- if_instruction_o  out  32  fetched word for the IF/ID register.
- if_bus_access_fault_o  out  1  fetched word came from a bus error.
- iport_addr_o  out  32  bus address.
- iport_cyc_o  out  1  bus cycle.
- iport_stb_o  out  1  bus strobe.
- iport_dat_i  in  32  read data.
- iport_ack_i  in  1  transfer complete.
- iport_err_i  in  1  transfer error; exclusive with ack.

## Operation
States: IDLE, REQ, HOLD, DRAIN. The state reaches IDLE on reset.
- IDLE:
  - cyc=stb=0, if_stall_o=1.
  - Unconditional next state is REQ.
- REQ:
  - cyc=stb=1, iport_addr_o=if_pc_i (combinational).
  - addr_q<=if_pc_i every cycle.
  - No ack/err, no redirect: if_stall_o=1, stay.
  - ack, no redirect:
    - if_instruction_o=iport_dat_i, if_stall_o=0.
    - id_stall_i=0: stay REQ. The next PC is fetched back-to-back.
    - id_stall_i=1: buf<=iport_dat_i, go HOLD.
  - err, no redirect: same as ack, but the word is NOP_INST, if_bus_access_fault_o=1, and buf_fault<=1.
  - redirect with ack/err: response discarded, if_kill_o=1, if_stall_o=0, next REQ.
  - redirect without ack/err: if_kill_o=1, if_stall_o=0 (PC loads target), go DRAIN.
- HOLD:
  - cyc=stb=0, if_stall_o=0.
  - if_instruction_o=buf, fault=buf_fault.
  - id_stall_i=0, no redirect: go REQ.
  - redirect: buffer dropped, if_kill_o=1, go REQ.
- DRAIN:
  - cyc=stb=1, iport_addr_o=addr_q (stale address held; Wishbone forbids dropping stb mid-transfer).
  - if_stall_o=1, if_kill_o=1.
  - ack/err: response discarded, go REQ.
  - redirect in DRAIN: PC reg takes target (if_stall_o forced 0 that cycle), stay DRAIN.
- Priority: rst_i > redirect > ack/err > id_stall_i.
- Any valid ack/err accepted while already HOLD is impossible (cyc=0); ack/err with cyc=0 is ignored.
- if_redirect_i always forces if_stall_o=0 so the PC register never loses a target.

## Timing
- Reset values (cycle after rst_i sampled high):
  - State: IDLE, so cyc=stb=0 and if_stall_o=1.
  - if_kill_o=0, if_bus_access_fault_o=0, if_instruction_o=NOP_INST.
  - addr_q=RESET_ADDR, buf=NOP_INST, buf_fault=0.
- First strobe is 1 cycle after reset release.
- Zero-wait-state memory (ack in strobe cycle) gives 1 instruction/cycle. An N-wait-state memory gives 1 per N+1 cycles.
- Reset mid-transfer: cyc drops at the next edge; the late ack is ignored.
- Outputs are combinational from state, buffers and bus inputs; state, addr_q and buf are registered.

## Structure
- The titan_defines header holds the state encodings (2-bit: IDLE=0, REQ=1, HOLD=2, DRAIN=3) and the RISC-V NOP constant. The ID stage shares the NOP constant for bubbles.
- Single flat module, no sub-module. It is instantiated beside the PC register/IF-ID register inside the IF stage; the top level ORs if_stall_o with the hazard stall.

## Test plan
- Reset with PC=0x0, ack same cycle, 4 cycles: addresses 0x0,0x4,0x8,0xC on consecutive cycles, if_stall_o=0 throughout.
- 2-wait-state memory returns 0x00500093 for PC 0x10: if_stall_o=1 for 2 cycles, then 0x00500093 with stall=0.
- Ack 0x00A00113 while id_stall_i=1 for 3 cycles: enter HOLD, output 0x00A00113 stable, cyc=0, next strobe 1 cycle after id_stall_i falls.
- Redirect to 0x100 at cycle 1 of a 3-wait fetch at 0x20: DRAIN keeps addr 0x20, ack data dropped, next strobe at 0x100, if_kill_o=1 until the drain ack.
- err on fetch at 0x40: if_instruction_o=0x00000013, if_bus_access_fault_o=1 for one cycle, next fetch at 0x44.
- rst_i pulsed during wait state: cyc=0 next cycle, late ack ignored, refetch from RESET_ADDR.

Source files
------------

// File: rtl/titan_fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: FSM state encoding and the RISC-V NOP
// word that the ID stage also uses for bubbles.
package titan_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/titan_fetch_ctrl.sv
// Instruction-fetch bus controller: Wishbone-classic instruction port driver with
// decode-stall holding buffer and redirect-kill of stale in-flight responses.
module titan_fetch_ctrl
  import titan_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = RV_NOP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  input  logic        if_redirect_i,
  input  logic        id_stall_i,
  output logic        if_stall_o,
  output logic        if_kill_o,
  output logic [31:0] if_instruction_o,
  output logic        if_bus_access_fault_o,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_dat_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q;
  logic [31:0]  hold_q;
  logic         hold_fault_q;
  logic         hold_load;
  logic         resp;
  logic [31:0]  resp_word;

  assign resp      = iport_ack_i | iport_err_i;
  assign resp_word = iport_err_i ? NOP_INST : iport_dat_i;

  always_comb begin
    state_d               = state_q;
    if_stall_o            = 1'b1;
    if_kill_o             = 1'b0;
    if_instruction_o      = NOP_INST;
    if_bus_access_fault_o = 1'b0;
    iport_addr_o          = addr_q;
    iport_cyc_o           = 1'b0;
    hold_load             = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
        if (if_redirect_i) begin
          if_stall_o = 1'b0;
          if_kill_o  = 1'b1;
        end
      end

      FETCH_REQ: begin
        iport_cyc_o  = 1'b1;
        iport_addr_o = if_pc_i;
        if (if_redirect_i) begin
          // A response landing with the redirect is stale; without one the
          // transfer is still open and must be drained before refetching.
          if_stall_o = 1'b0;
          if_kill_o  = 1'b1;
          state_d    = resp ? FETCH_REQ : FETCH_DRAIN;
        end else if (resp) begin
          if_stall_o            = 1'b0;
          if_instruction_o      = resp_word;
          if_bus_access_fault_o = iport_err_i;
          if (id_stall_i) begin
            hold_load = 1'b1;
            state_d   = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if_stall_o = 1'b0;
        if (if_redirect_i) begin
          if_kill_o = 1'b1;
          state_d   = FETCH_REQ;
        end else begin
          if_instruction_o      = hold_q;
          if_bus_access_fault_o = hold_fault_q;
          if (!id_stall_i) state_d = FETCH_REQ;
        end
      end

      FETCH_DRAIN: begin
        iport_cyc_o = 1'b1;
        if_kill_o   = 1'b1;
        if (if_redirect_i) begin
          if_stall_o = 1'b0;
        end else if (resp) begin
          state_d = FETCH_REQ;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  assign iport_stb_o = iport_cyc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH_IDLE;
      addr_q       <= RESET_ADDR;
      hold_q       <= NOP_INST;
      hold_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Captured every REQ cycle so DRAIN can keep presenting the stale address.
      if (state_q == FETCH_REQ) addr_q <= if_pc_i;
      if (hold_load) begin
        hold_q       <= resp_word;
        hold_fault_q <= iport_err_i;
      end
    end
  end

endmodule
